// File: rtl/xilinx_distram_fifo_ctrl.sv
// FIFO controller for an external dual-port distributed RAM: pointers, occupancy and a registered output stage.
// Optional: define XILINX_DISTRAM_FIFO_ALMOST_FULL_EN to add a registered ALMOST_FULL output.
module xilinx_distram_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned AFULL_THRESH = (2 ** ADDR_WIDTH) - 4
) (
  input  logic                  WCLK,
  input  logic                  RST,
  input  logic                  S_VALID,
  output logic                  S_READY,
  input  logic [DATA_WIDTH-1:0] S_DATA,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic [DATA_WIDTH-1:0] M_DATA,
  output logic [ADDR_WIDTH-1:0] RAM_A,
  output logic [DATA_WIDTH-1:0] RAM_D,
  output logic                  RAM_WE,
  output logic [ADDR_WIDTH-1:0] RAM_DPRA,
  input  logic [DATA_WIDTH-1:0] RAM_DPO,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [ADDR_WIDTH:0]   COUNT
`ifdef XILINX_DISTRAM_FIFO_ALMOST_FULL_EN
  ,
  output logic                  ALMOST_FULL
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  full;
  logic                  push;
  logic                  load;

  // Status depends only on registered state; RST blocks the write strobe so a coincident push is dropped.
  assign full    = (ram_cnt == DEPTH_CNT);
  assign push    = S_VALID & ~full & ~RST;
  assign load    = (ram_cnt != '0) & (~m_valid | M_READY);

  assign S_READY  = ~full;
  assign FULL     = full;
  assign EMPTY    = (ram_cnt == '0) & ~m_valid;
  assign COUNT    = ram_cnt + {{ADDR_WIDTH{1'b0}}, m_valid};
  assign RAM_A    = wptr;
  assign RAM_D    = S_DATA;
  assign RAM_WE   = push;
  assign RAM_DPRA = rptr;
  assign M_VALID  = m_valid;
  assign M_DATA   = m_data;

  always_ff @(posedge WCLK) begin
    if (RST) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_cnt <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (load) begin
        m_data  <= RAM_DPO;
        m_valid <= 1'b1;
        rptr    <= rptr + 1'b1;
      end else if (m_valid & M_READY) begin
        m_valid <= 1'b0;
      end
      if (push & ~load) begin
        ram_cnt <= ram_cnt + 1'b1;
      end else if (load & ~push) begin
        ram_cnt <= ram_cnt - 1'b1;
      end
    end
  end

`ifdef XILINX_DISTRAM_FIFO_ALMOST_FULL_EN
  localparam logic [ADDR_WIDTH:0] AFULL_CNT = (ADDR_WIDTH + 1)'(AFULL_THRESH);

  // Samples the current occupancy, so the flag trails each occupancy change by one edge.
  always_ff @(posedge WCLK) begin
    if (RST) begin
      ALMOST_FULL <= 1'b0;
    end else begin
      ALMOST_FULL <= (ram_cnt >= AFULL_CNT);
    end
  end
`endif

endmodule

// File: tb/tb_xilinx_distram_fifo_ctrl.sv
// Randomized bench for xilinx_distram_fifo_ctrl with an external RAM model and a queue-based reference.
module tb_xilinx_distram_fifo_ctrl;

  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned THR   = 60;

  logic          WCLK = 1'b0;
  logic          RST;
  logic          S_VALID;
  logic          S_READY;
  logic [DW-1:0] S_DATA;
  logic          M_VALID;
  logic          M_READY;
  logic [DW-1:0] M_DATA;
  logic [AW-1:0] RAM_A;
  logic [DW-1:0] RAM_D;
  logic          RAM_WE;
  logic [AW-1:0] RAM_DPRA;
  logic [DW-1:0] RAM_DPO;
  logic          FULL;
  logic          EMPTY;
  logic [AW:0]   COUNT;
`ifdef XILINX_DISTRAM_FIFO_ALMOST_FULL_EN
  logic          ALMOST_FULL;
`endif

  xilinx_distram_fifo_ctrl #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .AFULL_THRESH(THR)
  ) dut (
    .WCLK    (WCLK),
    .RST     (RST),
    .S_VALID (S_VALID),
    .S_READY (S_READY),
    .S_DATA  (S_DATA),
    .M_VALID (M_VALID),
    .M_READY (M_READY),
    .M_DATA  (M_DATA),
    .RAM_A   (RAM_A),
    .RAM_D   (RAM_D),
    .RAM_WE  (RAM_WE),
    .RAM_DPRA(RAM_DPRA),
    .RAM_DPO (RAM_DPO),
    .FULL    (FULL),
    .EMPTY   (EMPTY),
    .COUNT   (COUNT)
`ifdef XILINX_DISTRAM_FIFO_ALMOST_FULL_EN
    ,
    .ALMOST_FULL(ALMOST_FULL)
`endif
  );

  always #5 WCLK = ~WCLK;

  // Distributed RAM: synchronous write, asynchronous read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge WCLK) begin
    if (RAM_WE) mem[RAM_A] <= RAM_D;
  end
  assign RAM_DPO = mem[RAM_DPRA];

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: RAM occupancy as a queue plus the output register.
  logic [DW-1:0] ram_q[$];
  logic          ov_m;
  logic [DW-1:0] od_m;
  int unsigned   pushes_m;
  int unsigned   loads_m;
  logic          af_m;
  int unsigned   seq;

  task automatic model_reset();
    ram_q.delete();
    ov_m = 1'b0; od_m = '0; pushes_m = 0; loads_m = 0; af_m = 1'b0;
  endtask

  // Drive one cycle's inputs, check pre-edge outputs, then advance the model across the edge.
  task automatic cycle(input logic sv, input logic [DW-1:0] sd, input logic mr, input logic rst);
    logic full_m, push_m, load_m;
    S_VALID = sv; S_DATA = sd; M_READY = mr; RST = rst;
    #1;
    full_m = (ram_q.size() == DEPTH);
    push_m = sv & ~full_m & ~rst;
    load_m = (ram_q.size() != 0) & (~ov_m | mr);
    check("s_ready", S_READY, !full_m);
    check("full", FULL, full_m);
    check("empty", EMPTY, (ram_q.size() == 0) && !ov_m);
    check("count", COUNT, ram_q.size() + ov_m);
    check("m_valid", M_VALID, ov_m);
    check("m_data", M_DATA, od_m);
    check("ram_we", RAM_WE, push_m);
    check("ram_a", RAM_A, pushes_m % DEPTH);
    check("ram_d", RAM_D, sd);
    check("ram_dpra", RAM_DPRA, loads_m % DEPTH);
`ifdef XILINX_DISTRAM_FIFO_ALMOST_FULL_EN
    check("almost_full", ALMOST_FULL, af_m);
`endif
    @(posedge WCLK);
    if (rst) begin
      model_reset();
    end else begin
      af_m = (ram_q.size() >= THR);
      if (load_m) begin
        od_m = ram_q.pop_front();
        ov_m = 1'b1;
        loads_m++;
      end else if (ov_m && mr) begin
        ov_m = 1'b0;
      end
      if (push_m) begin
        ram_q.push_back(sd);
        pushes_m++;
        seq++;
      end
    end
    @(negedge WCLK);
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
    RST = 1'b1; S_VALID = 1'b0; S_DATA = '0; M_READY = 1'b0;
    model_reset();
    seq = 0;
    repeat (2) @(posedge WCLK);
    @(negedge WCLK);
    check("reset_count", COUNT, 0);
    check("reset_empty", EMPTY, 1);
    check("reset_s_ready", S_READY, 1);

    // Single push into empty: visible on the second edge.
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    check("single_mvalid_e1", M_VALID, 0);
    check("single_count_e1", COUNT, 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("single_mvalid_e2", M_VALID, 1);
    check("single_mdata_e2", M_DATA, 8'h11);

    // Fill from empty with 0x00..0x40, then keep offering the 66th word.
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    seq = 0;
    for (int i = 0; i < 70; i++) cycle(1'b1, DW'(seq), 1'b0, 1'b0);
    check("fill_count", COUNT, DEPTH + 1);
    check("fill_full", FULL, 1);
    check("fill_s_ready", S_READY, 0);

    // Drain.
    for (int i = 0; i < 70; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_empty", EMPTY, 1);
    check("drain_last", M_DATA, 8'h40);

    // Streaming 200 words; pointers wrap.
    seq = 0;
    for (int i = 0; i < 200; i++) cycle(1'b1, DW'(seq), 1'b1, 1'b0);
    check("stream_count", COUNT, 2);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset with COUNT=30, push coincident with RST is dropped.
    for (int i = 0; i < 30; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    check("pre_rst_count", COUNT, 30);
    cycle(1'b1, 8'hAA, 1'b0, 1'b1);
    check("post_rst_count", COUNT, 0);
    check("post_rst_mvalid", M_VALID, 0);
    check("post_rst_ram_a", RAM_A, 0);
    cycle(1'b1, 8'h55, 1'b0, 1'b0);

    // Randomized traffic with varying fill/drain bias, passing through almost-full.
    for (int p = 0; p < 6; p++) begin
      int unsigned pv = (p % 2 == 0) ? 90 : 30;
      int unsigned pr = (p % 2 == 0) ? 20 : 85;
      for (int i = 0; i < 300; i++) begin
        cycle(($urandom_range(99) < pv), DW'($urandom), ($urandom_range(99) < pr),
              ($urandom_range(999) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
